// File: rtl/mdu.sv
// RV32M multiply/divide unit. One radix-2 step per cycle over operand magnitudes:
// shift-add for multiply, restoring division for divide. Sign fix-up and the
// divide-by-zero override are applied as the result is captured on entry to DONE.
module mdu #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [2:0]      mdu_control,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] mdu_result
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q, state_d;
  logic [5:0]      cnt_q;
  logic [2:0]      op_q;
  logic [XLEN-1:0] opnd_q;  // multiplicand or divisor magnitude
  logic [XLEN-1:0] hi_q;    // product high half or partial remainder
  logic [XLEN-1:0] lo_q;    // multiplier bits or dividend/quotient bits
  logic            neg_q;   // result needs negation
  logic            dz_q;    // divide by zero

  logic            accept, last;
  logic            is_div, a_signed, b_signed, neg_a, neg_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [XLEN:0]   mul_sum, shifted;
  logic [XLEN-1:0] diff, hi_nx, lo_nx;
  logic            ge;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0] quo_s, rem_s, res_d;

  assign accept = start && (state_q != StBusy);
  assign last   = (state_q == StBusy) && (cnt_q == 6'(XLEN - 1));

  // Operand decode at acceptance: signedness per funct3, magnitudes, result sign.
  always_comb begin
    is_div   = mdu_control[2];
    a_signed = is_div ? ~mdu_control[0] : (mdu_control[1:0] != 2'b11);
    b_signed = is_div ? ~mdu_control[0] : ~mdu_control[1];
    neg_a    = a_signed && A[XLEN-1];
    neg_b    = b_signed && B[XLEN-1];
    mag_a    = neg_a ? -A : A;
    mag_b    = neg_b ? -B : B;
  end

  // One iteration of either shift-add multiply or restoring divide.
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    shifted = {hi_q, lo_q[XLEN-1]};
    ge      = shifted >= {1'b0, opnd_q};
    diff    = shifted[XLEN-1:0] - opnd_q;
    if (op_q[2]) begin
      hi_nx = ge ? diff : shifted[XLEN-1:0];
      lo_nx = {lo_q[XLEN-2:0], ge};
    end else begin
      hi_nx = mul_sum[XLEN:1];
      lo_nx = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  // Final result from the last iteration's outputs, with sign fix-up.
  always_comb begin
    prod   = {hi_nx, lo_nx};
    prod_s = neg_q ? -prod : prod;
    quo_s  = neg_q ? -lo_nx : lo_nx;
    rem_s  = neg_q ? -hi_nx : hi_nx;
    case (op_q)
      3'b000:                 res_d = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: res_d = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         res_d = dz_q ? '1 : quo_s;
      default:                res_d = rem_s;  // rem by zero falls out as A naturally
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = start ? StBusy : StIdle;
      StBusy:  state_d = last ? StDone : StBusy;
      StDone:  state_d = start ? StBusy : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Status outputs decoded from state.
  always_comb begin
    busy = (state_q == StBusy);
    done = (state_q == StDone);
  end

  // Datapath: load on acceptance, iterate while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      op_q   <= '0;
      opnd_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      neg_q  <= 1'b0;
      dz_q   <= 1'b0;
    end else if (accept) begin
      cnt_q  <= '0;
      op_q   <= mdu_control;
      opnd_q <= is_div ? mag_b : mag_a;
      hi_q   <= '0;
      lo_q   <= is_div ? mag_a : mag_b;
      neg_q  <= (is_div && mdu_control[1]) ? neg_a : (neg_a ^ neg_b);
      dz_q   <= (B == '0);
    end else if (state_q == StBusy) begin
      cnt_q <= cnt_q + 6'd1;
      hi_q  <= hi_nx;
      lo_q  <= lo_nx;
    end
  end

  // Result register: changes only on reset or on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst)       mdu_result <= '0;
    else if (last) mdu_result <= res_d;
  end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 The block SHALL use one clock and reset: `clk` (rising edge) and `rst`, where `rst` is synchronous and active-high.
REQ-002 Port `clk` SHALL be: input, 1 bit, system clock.
REQ-003 Port `rst` SHALL be: input, 1 bit, synchronous active-high reset.
REQ-004 Port `A` SHALL be: input, 32 bits, operand rs1 (multiplicand / dividend).
REQ-005 Port `B` SHALL be: input, 32 bits, operand rs2 (multiplier / divisor).
REQ-006 Port `mdu_control` SHALL be: input, 3 bits, RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 Port `start` SHALL be: input, 1 bit, request; sampled only in IDLE or DONE.
REQ-008 Port `busy` SHALL be: output, 1 bit, high while the operation is in progress (BUSY state).
REQ-009 Port `done` SHALL be: output, 1 bit, one-cycle pulse, `mdu_result` valid.
REQ-010 Port `mdu_result` SHALL be: output, 32 bits, result, held until the next completion.
REQ-011 Parameter `XLEN` SHALL have default 32: the operand width; only 32 is required to be supported.

Function
REQ-012 The FSM SHALL have three states: IDLE, BUSY, DONE.
REQ-013 IDLE with `start`=1: latch `A`, `B` and `mdu_control`, clear the 6-bit iteration counter, go to BUSY.
REQ-014 IDLE with `start`=0: remain in IDLE.
REQ-015 BUSY: perform one radix-2 iteration per cycle; after 32 iterations (counter = 31), go to DONE.
REQ-016 DONE: `done`=1 for exactly that cycle and `mdu_result` is updated on entry to DONE.
REQ-017 DONE with `start`=1: accept the new operation (same as REQ-013).
REQ-018 DONE with `start`=0: go to IDLE.
REQ-019 Latency SHALL be fixed: with `start` sampled at edge k, `done` is high in the cycle after edge k+33, for every op including special cases.
REQ-020 `busy` SHALL be 1 exactly in BUSY (32 cycles), and 0 in IDLE and DONE.
REQ-021 `start` while in BUSY SHALL be ignored, with no queuing and no effect on the in-flight op.
REQ-022 Input changes on `A`, `B` or `mdu_control` after acceptance SHALL NOT affect the in-flight result.
REQ-023 Multiply: shift-add on the 64-bit product of operand magnitudes, with sign fix-up at completion.
- MUL returns product[31:0].
- MULH returns signed×signed [63:32].
- MULHSU returns signed `A` × unsigned `B` [63:32].
- MULHU returns unsigned×unsigned [63:32].
REQ-024 Divide: restoring division on magnitudes; quotient sign = sign(A) XOR sign(B) (signed ops); remainder sign = sign(A); results truncate toward zero.
REQ-025 Divide by zero (`B`=0): DIV/DIVU = 0xFFFFFFFF; REM/REMU = `A`.
REQ-026 Signed overflow (`A`=0x80000000, `B`=0xFFFFFFFF): DIV = 0x80000000; REM = 0.
REQ-027 Special cases in REQ-025/REQ-026 SHALL still obey the latency in REQ-019.
REQ-028 `mdu_result` SHALL change only on entry to DONE or on reset.
REQ-029 No internal state SHALL persist across operations other than `mdu_result`.

Reset
REQ-030 `rst`=1 at a rising edge SHALL force state IDLE, `busy`=0, `done`=0, `mdu_result`=0 and counter=0, regardless of state.
REQ-031 Reset mid-operation (BUSY) SHALL abort the op; no `done` pulse is produced for it.
REQ-032 `rst` and `start` high at the same edge: reset wins and `start` is ignored.
REQ-033 First `start` accepted is at the first edge with `rst`=0.

Verification
REQ-034 Scenario: MUL `A`=7, `B`=-3 (0xFFFFFFFD) -> `done` 33 cycles after start, `mdu_result`=0xFFFFFFEB.
REQ-035 Scenario: MULH `A`=0x80000000, `B`=0x80000000 -> 0x40000000; MULHU `A`=`B`=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU `A`=-1, `B`=0xFFFFFFFF -> 0xFFFFFFFF.
REQ-036 Scenario: DIV `A`=-7, `B`=2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF; DIVU `A`=100, `B`=7 -> 14; REMU -> 2.
REQ-037 Scenario: DIVU/REMU `B`=0, `A`=0x1234 -> 0xFFFFFFFF and 0x1234; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0; each with latency 33.
REQ-038 Scenario: `start` re-pulsed during BUSY with different operands -> ignored, original result delivered; `start` in the DONE cycle -> next `done` 33 cycles later.
REQ-039 Scenario: `rst` asserted at BUSY iteration 10 -> next cycle `busy`=0, `mdu_result`=0, and no `done` pulse is seen for 40 cycles.
